// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage branch/load hazard stall controller.
package branch_hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } bh_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module branch_hazard_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage stall controller: detects hazards decode forwarding cannot cover and
// runs a 1- or 2-cycle stall, with saturating debug counters.
//   state | meaning
//   IDLE  | no sequence in progress; hazards evaluated, first stall cycle issued here
//   HOLD  | second stall cycle of a branch-after-load sequence; inputs ignored
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cnt_clear,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_branch,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [NB_REG-1:0] ex_write_reg,
  input  logic              mem_mem_read,
  input  logic [NB_REG-1:0] mem_write_reg,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              stall,
  output logic [NB_CNT-1:0] stall_cycles,
  output logic [NB_CNT-1:0] hazard_events
);

  localparam logic [NB_REG-1:0] REG0 = NB_REG'(REG_ZERO);

  bh_state_t state, state_nxt;
  logic      m_ex, m_mem, haz_2, haz_1, seq_start;

  assign m_ex  = (ex_write_reg != REG0) &&
                 ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
  assign m_mem = (mem_write_reg != REG0) &&
                 ((mem_write_reg == id_rs) || (id_uses_rt && (mem_write_reg == id_rt)));

  // A load in EX feeding a branch needs two cycles: one to reach MEM, one to reach WB.
  assign haz_2 = id_branch & ex_mem_read & m_ex;
  assign haz_1 = (id_branch & ex_reg_write & ~ex_mem_read & m_ex) |
                 (id_branch & mem_mem_read & m_mem) |
                 (~id_branch & ex_mem_read & m_ex);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    seq_start = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (haz_2 || haz_1) begin
            stall     = 1'b1;
            seq_start = 1'b1;
          end
          if (haz_2) state_nxt = HOLD;
        end
        HOLD: begin
          stall     = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign pc_write     = enable & ~stall;
  assign if_id_write  = enable & ~stall;
  assign id_ex_bubble = stall;

  branch_hazard_ctrl_sat_counter #(.W(NB_CNT)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .clr   (cnt_clear),
    .cnt   (stall_cycles)
  );

  branch_hazard_ctrl_sat_counter #(.W(NB_CNT)) u_event_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (seq_start),
    .clr   (cnt_clear),
    .cnt   (hazard_events)
  );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_branch_hazard_ctrl;

  localparam int NB_REG = 5;
  localparam int NB_CNT = 4;

  logic              clk = 1'b0;
  logic              rst_n, enable, cnt_clear;
  logic [NB_REG-1:0] id_rs, id_rt, ex_write_reg, mem_write_reg;
  logic              id_uses_rt, id_branch, ex_reg_write, ex_mem_read, mem_mem_read;
  logic              pc_write, if_id_write, id_ex_bubble, stall;
  logic [NB_CNT-1:0] stall_cycles, hazard_events;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cnt_clear     (cnt_clear),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_branch     (id_branch),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_write_reg  (ex_write_reg),
    .mem_mem_read  (mem_mem_read),
    .mem_write_reg (mem_write_reg),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_bubble  (id_ex_bubble),
    .stall         (stall),
    .stall_cycles  (stall_cycles),
    .hazard_events (hazard_events)
  );

  typedef struct {
    logic       en;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       branch;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] ex_wr;
    logic       mem_mr;
    logic [4:0] mem_wr;
    logic       exp_stall;
    logic       exp_pcw;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic branch, input logic ex_rw,
                       input logic ex_mr, input logic [4:0] ex_wr,
                       input logic mem_mr, input logic [4:0] mem_wr);
    enable = en; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_branch = branch;
    ex_reg_write = ex_rw; ex_mem_read = ex_mr; ex_write_reg = ex_wr;
    mem_mem_read = mem_mr; mem_write_reg = mem_wr;
    #1;
  endtask

  task automatic benign();
    drive(1, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_counters();
    benign();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("clear_stall_cycles", 16'(stall_cycles), 16'd0);
  endtask

  initial begin
    vecs[0]  = '{1, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1};  // no hazard
    vecs[1]  = '{1, 5'd8, 5'd2, 0, 0, 1, 1, 5'd8, 0, 5'd0, 1, 0};  // load-use rs
    vecs[2]  = '{1, 5'd3, 5'd8, 1, 0, 1, 1, 5'd8, 0, 5'd0, 1, 0};  // load-use rt
    vecs[3]  = '{1, 5'd3, 5'd8, 0, 0, 1, 1, 5'd8, 0, 5'd0, 0, 1};  // rt unused
    vecs[4]  = '{1, 5'd0, 5'd0, 1, 0, 1, 1, 5'd0, 0, 5'd0, 0, 1};  // r0 never matches
    vecs[5]  = '{1, 5'd5, 5'd2, 0, 1, 1, 0, 5'd5, 0, 5'd0, 1, 0};  // branch <- EX ALU
    vecs[6]  = '{1, 5'd5, 5'd2, 0, 1, 0, 0, 5'd5, 0, 5'd0, 0, 1};  // EX not writing
    vecs[7]  = '{1, 5'd4, 5'd7, 1, 1, 0, 0, 5'd0, 1, 5'd7, 1, 0};  // branch <- MEM load
    vecs[8]  = '{1, 5'd4, 5'd7, 1, 1, 0, 0, 5'd0, 0, 5'd7, 0, 1};  // MEM ALU forwarded
    vecs[9]  = '{1, 5'd7, 5'd2, 0, 0, 0, 0, 5'd0, 1, 5'd7, 0, 1};  // non-branch, MEM load
    vecs[10] = '{0, 5'd8, 5'd2, 0, 0, 1, 1, 5'd8, 0, 5'd0, 0, 0};  // frozen
    vecs[11] = '{1, 5'd6, 5'd2, 0, 0, 1, 0, 5'd6, 0, 5'd0, 0, 1};  // non-branch EX ALU

    rst_n = 1'b0; cnt_clear = 1'b0;
    benign();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-HOLD aborts the sequence and clears counters
    drive(1, 5'd2, 5'd9, 1, 1, 1, 1, 5'd9, 0, 5'd0);
    chk("t1_h2_stall", 16'(stall), 16'd1);
    tick();
    benign();
    chk("t1_hold_stall", 16'(stall), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_stall", 16'(stall), 16'd0);
    chk("t1_rst_stall_cycles", 16'(stall_cycles), 16'd0);
    chk("t1_rst_hazard_events", 16'(hazard_events), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t1_post_pc_write", 16'(pc_write), 16'd1);
    chk("t1_post_stall", 16'(stall), 16'd0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en, vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].branch,
            vecs[i].ex_rw, vecs[i].ex_mr, vecs[i].ex_wr, vecs[i].mem_mr, vecs[i].mem_wr);
      chk($sformatf("vec%0d_stall", i), 16'(stall), 16'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_bubble", i), 16'(id_ex_bubble), 16'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_pc_write", i), 16'(pc_write), 16'(vecs[i].exp_pcw));
      chk($sformatf("vec%0d_if_id_write", i), 16'(if_id_write), 16'(vecs[i].exp_pcw));
      tick();
    end
    chk("table_stall_cycles", 16'(stall_cycles), 16'd4);
    chk("table_hazard_events", 16'(hazard_events), 16'd4);

    // Load-use: exactly one stall cycle
    clear_counters();
    drive(1, 5'd8, 5'd2, 0, 0, 1, 1, 5'd8, 0, 5'd0);
    chk("t2_stall", 16'(stall), 16'd1);
    tick();
    benign();
    chk("t2_after_stall", 16'(stall), 16'd0);
    chk("t2_stall_cycles", 16'(stall_cycles), 16'd1);
    chk("t2_hazard_events", 16'(hazard_events), 16'd1);

    // Branch after load: two stalls even though inputs turn benign
    clear_counters();
    drive(1, 5'd2, 5'd9, 1, 1, 1, 1, 5'd9, 0, 5'd0);
    chk("t3_stall_c1", 16'(stall), 16'd1);
    tick();
    benign();
    chk("t3_stall_c2", 16'(stall), 16'd1);
    chk("t3_pc_write_c2", 16'(pc_write), 16'd0);
    tick();
    chk("t3_stall_c3", 16'(stall), 16'd0);
    chk("t3_stall_cycles", 16'(stall_cycles), 16'd2);
    chk("t3_hazard_events", 16'(hazard_events), 16'd1);

    // Enable drop while in HOLD: freeze, then resume the remaining stall cycle
    clear_counters();
    drive(1, 5'd9, 5'd2, 0, 1, 1, 1, 5'd9, 0, 5'd0);
    chk("t5_stall_c1", 16'(stall), 16'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 0, 5'd0);
      chk("t5_frozen_stall", 16'(stall), 16'd0);
      chk("t5_frozen_pc_write", 16'(pc_write), 16'd0);
      chk("t5_frozen_bubble", 16'(id_ex_bubble), 16'd0);
      tick();
      chk("t5_frozen_stall_cycles", 16'(stall_cycles), 16'd1);
      chk("t5_frozen_hazard_events", 16'(hazard_events), 16'd1);
    end
    benign();
    chk("t5_resume_stall", 16'(stall), 16'd1);
    tick();
    chk("t5_idle_stall", 16'(stall), 16'd0);
    chk("t5_stall_cycles", 16'(stall_cycles), 16'd2);
    chk("t5_hazard_events", 16'(hazard_events), 16'd1);

    // Saturation at 4'hF, then clear beats increment
    clear_counters();
    drive(1, 5'd8, 5'd2, 0, 0, 1, 1, 5'd8, 0, 5'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_sat_stall_cycles", 16'(stall_cycles), 16'd15);
    chk("t6_sat_hazard_events", 16'(hazard_events), 16'd15);
    chk("t6_stall_during_clear", 16'(stall), 16'd1);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("t6_clr_stall_cycles", 16'(stall_cycles), 16'd0);
    chk("t6_clr_hazard_events", 16'(hazard_events), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
